// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite control/status register block: NREG R/W control words, NSTAT read-only status words,
// byte strobes, SLVERR on unmapped offsets, self-clearing start. Optional IRQ register under CTRL_IRQ_EN.
module axil_ctrl_regs #(
    parameter int ADDR_W = 12,
    parameter int NREG   = 8,
    parameter int NSTAT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [32*NREG-1:0]    ctrl,
    output logic                  start,
    input  logic [32*NSTAT-1:0]   status,
    input  logic                  done,
    output logic                  irq
);

    typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, BRESP, RD, RRESP} state_t;

    localparam logic [31:0] STAT_BASE   = 32'h100;
    localparam logic [31:0] IRQ_WORD    = 32'h200;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t            state;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic [31:0]       ctrl_q [NREG];
    logic              bvalid_q;
    logic              rvalid_q;
    logic              start_q;
    logic [1:0]        bresp_q;
    logic [1:0]        rresp_q;
    logic [31:0]       rdata_q;

    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_fire;
    logic [31:0]       wr_widx;
    logic              wr_ctrl;
    logic              wr_irq;
    logic [31:0]       rd_widx;
    logic [31:0]       rd_data;
    logic              rd_err;

`ifdef CTRL_IRQ_EN
    logic irq_pend;
    logic irq_en;
    logic irq_q;
    logic pend_next;
    logic en_next;
    logic irq_wr;
`endif

    // AR is only offered when no write is pending, so a write always wins a tie
    assign S_AXI_AWREADY = (state == IDLE) || (state == WAIT_AW);
    assign S_AXI_WREADY  = (state == IDLE) || (state == WAIT_W);
    assign S_AXI_ARREADY = (state == IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign start         = start_q;

    for (genvar g = 0; g < NREG; g++) begin : g_ctrl
        assign ctrl[32*g +: 32] = ctrl_q[g];
    end

    // Merge the held half of a split write with the channel completing it
    always_comb begin
        wr_addr = aw_addr_q;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        wr_fire = 1'b0;
        case (state)
            IDLE: begin
                wr_addr = S_AXI_AWADDR;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
                wr_fire = S_AXI_AWVALID && S_AXI_WVALID;
            end
            WAIT_W: begin
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
                wr_fire = S_AXI_WVALID;
            end
            WAIT_AW: begin
                wr_addr = S_AXI_AWADDR;
                wr_fire = S_AXI_AWVALID;
            end
            default: ;
        endcase
        wr_widx = 32'(wr_addr[ADDR_W-1:2]);
        wr_ctrl = wr_widx < 32'(NREG);
`ifdef CTRL_IRQ_EN
        wr_irq  = wr_widx == IRQ_WORD;
`else
        wr_irq  = 1'b0;
`endif
    end

    always_comb begin
        rd_widx = 32'(ar_addr_q[ADDR_W-1:2]);
        rd_data = '0;
        rd_err  = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            if (rd_widx == 32'(i)) begin
                rd_data = ctrl_q[i];
                rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < NSTAT; j++) begin
            if (rd_widx == STAT_BASE + 32'(j)) begin
                rd_data = status[32*j +: 32];
                rd_err  = 1'b0;
            end
        end
`ifdef CTRL_IRQ_EN
        if (rd_widx == IRQ_WORD) begin
            rd_data = {30'd0, irq_en, irq_pend};
            rd_err  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            aw_addr_q <= '0;
            ar_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            start_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NREG; i++) ctrl_q[i] <= '0;
        end else begin
            start_q <= 1'b0;
            if (wr_fire) begin
                for (int i = 0; i < NREG; i++) begin
                    for (int k = 0; k < 4; k++) begin
                        if (wr_ctrl && wr_widx == 32'(i) && wr_strb[k])
                            ctrl_q[i][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
                start_q  <= wr_ctrl && (wr_widx == 32'd0) && wr_strb[3] && wr_data[31];
                bresp_q  <= (wr_ctrl || wr_irq) ? RESP_OKAY : RESP_SLVERR;
                bvalid_q <= 1'b1;
                state    <= BRESP;
            end
            case (state)
                IDLE: begin
                    if (!wr_fire) begin
                        if (S_AXI_AWVALID) begin
                            aw_addr_q <= S_AXI_AWADDR;
                            state     <= WAIT_W;
                        end else if (S_AXI_WVALID) begin
                            w_data_q <= S_AXI_WDATA;
                            w_strb_q <= S_AXI_WSTRB;
                            state    <= WAIT_AW;
                        end else if (S_AXI_ARVALID) begin
                            ar_addr_q <= S_AXI_ARADDR;
                            state     <= RD;
                        end
                    end
                end
                BRESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RD: begin
                    rdata_q  <= rd_data;
                    rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    rvalid_q <= 1'b1;
                    state    <= RRESP;
                end
                RRESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: ;
            endcase
            // Start bit of reg 0 is a trigger only and never holds a value
            ctrl_q[0][31] <= 1'b0;
        end
    end

`ifdef CTRL_IRQ_EN
    // A done pulse coinciding with a write-1-to-clear keeps the interrupt pending
    always_comb begin
        irq_wr    = wr_fire && wr_irq && wr_strb[0];
        pend_next = done || (irq_pend && !(irq_wr && wr_data[0]));
        en_next   = irq_wr ? wr_data[1] : irq_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pend <= 1'b0;
            irq_en   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_pend <= pend_next;
            irq_en   <= en_next;
            irq_q    <= pend_next && en_next;
        end
    end

    assign irq = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wr_addr[1:0], ar_addr_q[1:0]};
`else
    assign irq = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wr_addr[1:0], ar_addr_q[1:0], done};
`endif

endmodule

// File: tb/tb_axil_ctrl_regs.sv
// Scoreboard bench for axil_ctrl_regs: directed AXI-Lite writes/reads, expected responses queued
// by the stimulus and checked by an independent monitor. Covers either CTRL_IRQ_EN build.
module tb_axil_ctrl_regs;

   localparam int ADDR_W = 12;
   localparam int NREG   = 8;
   localparam int NSTAT  = 4;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [ADDR_W-1:0]    awAddr;
   logic                 awValid;
   logic                 awReady;
   logic [31:0]          wData;
   logic [3:0]           wStrb;
   logic                 wValid;
   logic                 wReady;
   logic [1:0]           bResp;
   logic                 bValid;
   logic                 bReady;
   logic [ADDR_W-1:0]    arAddr;
   logic                 arValid;
   logic                 arReady;
   logic [31:0]          rData;
   logic [1:0]           rResp;
   logic                 rValid;
   logic                 rReady;
   logic [32*NREG-1:0]   ctrl;
   logic                 start;
   logic [32*NSTAT-1:0]  status;
   logic                 done;
   logic                 irq;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rExp_t;

   logic [1:0]  bQueue [$];
   rExp_t       rQueue [$];
   logic [31:0] expCtrl [NREG];
   int          vectors     = 0;
   int          miscompares = 0;
   int          startCount  = 0;
   logic [1:0]  bExp;
   rExp_t       rExp;

   always #5 clk = ~clk;

   axil_ctrl_regs #(.ADDR_W(ADDR_W), .NREG(NREG), .NSTAT(NSTAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .S_AXI_AWADDR  (awAddr),
      .S_AXI_AWVALID (awValid),
      .S_AXI_AWREADY (awReady),
      .S_AXI_WDATA   (wData),
      .S_AXI_WSTRB   (wStrb),
      .S_AXI_WVALID  (wValid),
      .S_AXI_WREADY  (wReady),
      .S_AXI_BRESP   (bResp),
      .S_AXI_BVALID  (bValid),
      .S_AXI_BREADY  (bReady),
      .S_AXI_ARADDR  (arAddr),
      .S_AXI_ARVALID (arValid),
      .S_AXI_ARREADY (arReady),
      .S_AXI_RDATA   (rData),
      .S_AXI_RRESP   (rResp),
      .S_AXI_RVALID  (rValid),
      .S_AXI_RREADY  (rReady),
      .ctrl          (ctrl),
      .start         (start),
      .status        (status),
      .done          (done),
      .irq           (irq)
   );

   // Counts start-pulse cycles so each write can be checked for exactly one pulse
   always @(negedge clk) begin
      if (!reset && start) startCount++;
   end

   // Monitor: pops the expected response whenever a B or R handshake is about to occur;
   // while R is stalled it checks the held data against the queue head
   always @(negedge clk) begin
      if (!reset) begin
         if (bValid && bReady) begin
            vectors++;
            if (bQueue.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL bresp: got unexpected response %b, required none", bResp);
            end else begin
               bExp = bQueue.pop_front();
               if (bResp !== bExp) begin
                  miscompares++;
                  $display("[TB] FAIL bresp: got %b, required %b", bResp, bExp);
               end
            end
         end
         if (rValid) begin
            vectors++;
            if (rQueue.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL rdata: got unexpected response %h/%b, required none", rData, rResp);
            end else begin
               rExp = rQueue[0];
               if (rData !== rExp.data || rResp !== rExp.resp) begin
                  miscompares++;
                  $display("[TB] FAIL %s: got %h/%b, required %h/%b",
                           rReady ? "rdata" : "rdata_hold", rData, rResp, rExp.data, rExp.resp);
               end
               if (rReady) void'(rQueue.pop_front());
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   task automatic checkCtrl(input string tag);
      for (int i = 0; i < NREG; i++)
         checkOutput($sformatf("%s_ctrl%0d", tag, i), ctrl[32*i +: 32], expCtrl[i]);
   endtask

   task automatic timeoutFail(input string name);
      miscompares++;
      $display("[TB] FAIL %s: got timeout, required handshake", name);
   endtask

   // For writes, data/strb are the write payload; for reads, data is the expected RDATA.
   // wLead delays AWVALID by that many cycles behind WVALID; pulseDone raises done with the write.
   task automatic applyStimulus(input bit isWrite, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int wLead, input bit pulseDone,
                                input logic [1:0] expResp);
      bit awDone = 0, wDone = 0, awHs, wHs, arHs, seen = 0;
      int cyc = 0;
      if (isWrite) begin
         bQueue.push_back(expResp);
         awAddr = addr;
         wData  = data;
         wStrb  = strb;
         wValid = 1'b1;
         if (wLead == 0) awValid = 1'b1;
         if (pulseDone) done = 1'b1;
         while (!(awDone && wDone) && cyc < 50) begin
            @(negedge clk);
            awHs = awValid && awReady;
            wHs  = wValid && wReady;
            @(posedge clk); #1;
            done = 1'b0;
            if (awHs) begin awValid = 1'b0; awDone = 1; end
            if (wHs)  begin wValid  = 1'b0; wDone  = 1; end
            cyc++;
            if (!awDone && !awValid && cyc >= wLead) awValid = 1'b1;
         end
         if (!(awDone && wDone)) timeoutFail("write_addr_data");
         cyc = 0;
         @(negedge clk);
         while (bValid && cyc < 50) begin @(negedge clk); cyc++; end
         if (cyc >= 50) timeoutFail("write_resp");
      end else begin
         rQueue.push_back('{data, expResp});
         arAddr  = addr;
         arValid = 1'b1;
         arHs    = 0;
         while (!arHs && cyc < 50) begin
            @(negedge clk);
            arHs = arValid && arReady;
            @(posedge clk); #1;
            if (arHs) arValid = 1'b0;
            cyc++;
         end
         if (!arHs) timeoutFail("read_addr");
         cyc = 0;
         while (!seen && cyc < 50) begin
            @(negedge clk);
            if (rValid && rReady) seen = 1;
            cyc++;
         end
         if (!seen) timeoutFail("read_resp");
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bit awHs, wHs, arHs, arDone, bSeen;
      int cyc;
      int s0;

      reset   = 1'b1;
      awAddr  = '0; awValid = 1'b0;
      wData   = '0; wStrb   = '0; wValid = 1'b0;
      bReady  = 1'b1;
      arAddr  = '0; arValid = 1'b0;
      rReady  = 1'b1;
      status  = '0;
      done    = 1'b0;
      for (int i = 0; i < NREG; i++) expCtrl[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_bvalid", {31'd0, bValid}, 32'd0);
      checkOutput("reset_rvalid", {31'd0, rValid}, 32'd0);
      checkOutput("reset_rdata", rData, 32'd0);
      checkOutput("reset_start", {31'd0, start}, 32'd0);
      checkOutput("reset_irq", {31'd0, irq}, 32'd0);
      checkCtrl("reset");
      @(posedge clk); #1;

      applyStimulus(0, 12'h000, 32'h0000_0000, 4'h0, 0, 0, OKAY);

      // W leads AW by three cycles; strobes keep bytes 0 and 2 only
      applyStimulus(1, 12'h004, 32'h1234_5678, 4'b0101, 3, 0, OKAY);
      expCtrl[1] = 32'h0034_0078;
      checkOutput("strb_ctrl1", ctrl[32*1 +: 32], expCtrl[1]);
      applyStimulus(0, 12'h004, 32'h0034_0078, 4'h0, 0, 0, OKAY);

      s0 = startCount;
      applyStimulus(1, 12'h000, 32'h8000_0003, 4'hF, 0, 0, OKAY);
      expCtrl[0] = 32'h0000_0003;
      checkOutput("start_pulses", 32'(startCount - s0), 32'd1);
      checkOutput("start_ctrl0", ctrl[31:0], expCtrl[0]);
      applyStimulus(0, 12'h000, 32'h0000_0003, 4'h0, 0, 0, OKAY);

      // Bit 31 without its byte strobe: no start, low three bytes written
      s0 = startCount;
      applyStimulus(1, 12'h000, 32'hFFFF_FFFF, 4'b0111, 0, 0, OKAY);
      expCtrl[0] = 32'h00FF_FFFF;
      checkOutput("nostart_pulses", 32'(startCount - s0), 32'd0);
      s0 = startCount;
      applyStimulus(1, 12'h000, 32'h8000_0000, 4'b1000, 0, 0, OKAY);
      checkOutput("start_top_pulses", 32'(startCount - s0), 32'd1);
      applyStimulus(0, 12'h000, 32'h00FF_FFFF, 4'h0, 0, 0, OKAY);

      applyStimulus(1, 12'h01C, 32'hDEAD_BEEF, 4'b1000, 1, 0, OKAY);
      expCtrl[7] = 32'hDE00_0000;
      applyStimulus(0, 12'h01C, 32'hDE00_0000, 4'h0, 0, 0, OKAY);

      status[31:0]   = 32'hCAFE_F00D;
      status[127:96] = 32'h1357_9BDF;
      applyStimulus(0, 12'h400, 32'hCAFE_F00D, 4'h0, 0, 0, OKAY);
      applyStimulus(0, 12'h40C, 32'h1357_9BDF, 4'h0, 0, 0, OKAY);
      applyStimulus(0, 12'h410, 32'h0000_0000, 4'h0, 0, 0, SLVERR);
      applyStimulus(0, 12'h7FC, 32'h0000_0000, 4'h0, 0, 0, SLVERR);
      applyStimulus(1, 12'h400, 32'hFFFF_FFFF, 4'hF, 0, 0, SLVERR);
      applyStimulus(1, 12'h020, 32'hFFFF_FFFF, 4'hF, 0, 0, SLVERR);
      checkCtrl("unmapped");

      // AW, W and AR together: write must finish first, then the read sees its data
      bQueue.push_back(OKAY);
      rQueue.push_back('{32'h0000_AA55, OKAY});
      awAddr = 12'h008; wData = 32'h0000_AA55; wStrb = 4'hF; arAddr = 12'h008;
      rReady = 1'b0;
      awValid = 1'b1; wValid = 1'b1; arValid = 1'b1;
      arDone = 0; bSeen = 0; cyc = 0;
      while (!arDone && cyc < 50) begin
         @(negedge clk);
         awHs = awValid && awReady;
         wHs  = wValid && wReady;
         arHs = arValid && arReady;
         if (bValid && bReady) bSeen = 1;
         if (arHs) checkOutput("write_before_read", {31'd0, bSeen}, 32'd1);
         @(posedge clk); #1;
         if (awHs) awValid = 1'b0;
         if (wHs)  wValid  = 1'b0;
         if (arHs) begin arValid = 1'b0; arDone = 1; end
         cyc++;
      end
      if (!arDone) timeoutFail("tie_read_addr");
      expCtrl[2] = 32'h0000_AA55;
      cyc = 0;
      @(negedge clk);
      while (!rValid && cyc < 50) begin @(negedge clk); cyc++; end
      if (cyc >= 50) timeoutFail("tie_read_resp");
      repeat (4) @(negedge clk);
      checkOutput("rvalid_held", {31'd0, rValid}, 32'd1);
      @(posedge clk); #1;
      rReady = 1'b1;
      @(posedge clk); #1;
      checkOutput("rvalid_drop", {31'd0, rValid}, 32'd0);
      checkCtrl("tie");

`ifdef CTRL_IRQ_EN
      applyStimulus(1, 12'h800, 32'h0000_0002, 4'hF, 0, 0, OKAY);
      checkOutput("irq_enabled_idle", {31'd0, irq}, 32'd0);
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      checkOutput("irq_set", {31'd0, irq}, 32'd1);
      applyStimulus(1, 12'h800, 32'h0000_0003, 4'hF, 0, 1, OKAY);
      checkOutput("irq_set_wins", {31'd0, irq}, 32'd1);
      applyStimulus(1, 12'h800, 32'h0000_0003, 4'hF, 0, 0, OKAY);
      checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
      applyStimulus(0, 12'h800, 32'h0000_0002, 4'h0, 0, 0, OKAY);
`else
      applyStimulus(1, 12'h800, 32'h0000_0003, 4'hF, 0, 0, SLVERR);
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      @(posedge clk); #1;
      checkOutput("irq_tied_low", {31'd0, irq}, 32'd0);
      applyStimulus(0, 12'h800, 32'h0000_0000, 4'h0, 0, 0, SLVERR);
`endif

      repeat (3) @(posedge clk);
      checkOutput("bqueue_drained", 32'(bQueue.size()), 32'd0);
      checkOutput("rqueue_drained", 32'(rQueue.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
